// File: rtl/generador_pkg.sv
// Shared constants for the binary text generator:
// window origin, index widths, colours and the two-glyph font.
package generador_pkg;

    localparam logic [9:0] X0_DEF = 10'd256;
    localparam logic [9:0] Y0_DEF = 10'd224;

    localparam int CHAR_W = 3;
    localparam int ROW_W  = 4;
    localparam int COL_W  = 3;

    localparam logic [9:0] WIN_W = 10'd128;
    localparam logic [9:0] WIN_H = 10'd32;

    localparam logic [2:0] FG_RGB_DEF = 3'b111;
    localparam logic [2:0] BG_RGB_DEF = 3'b000;

    // [digit][row] -> 8-bit row, bit 7 is the leftmost column.
    // Rows are listed 15 down to 0.
    localparam logic [1:0][15:0][7:0] GLYPH = '{
        '{8'h00, 8'h00, 8'h3C, 8'h18,
          8'h18, 8'h18, 8'h18, 8'h18,
          8'h18, 8'h18, 8'h18, 8'h18,
          8'h38, 8'h18, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h3C, 8'h42,
          8'h42, 8'h42, 8'h42, 8'h42,
          8'h42, 8'h42, 8'h42, 8'h42,
          8'h42, 8'h3C, 8'h00, 8'h00}
    };

endpackage

// File: rtl/generador_datos_texto_font_rom_bin.sv
// Combinational font lookup: one 8-pixel row of glyph '0' or '1'.
module font_rom_bin
    import generador_pkg::*;
(
    input  logic             digit,
    input  logic [ROW_W-1:0] row,
    output logic [7:0]       row_bits
);

    assign row_bits = GLYPH[digit][row];

endmodule

// File: rtl/generador_datos_texto.sv
// Draws the switch value as eight binary characters, 2x scaled,
// inside a fixed window; one registered pixel of latency.
module generador_datos_texto
    import generador_pkg::*;
#(
    parameter logic [9:0] X0     = X0_DEF,
    parameter logic [9:0] Y0     = Y0_DEF,
    parameter logic [2:0] FG_RGB = FG_RGB_DEF,
    parameter logic [2:0] BG_RGB = BG_RGB_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic [7:0] switch,
    output logic [2:0] rgb_text
);

    localparam logic [9:0] X1 = X0 + WIN_W;
    localparam logic [9:0] Y1 = Y0 + WIN_H;

    logic              in_win;
    logic [5:0]        dx_half;
    logic [CHAR_W-1:0] char_idx;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              digit;
    logic [7:0]        row_bits;
    logic              pix_on;
    logic [2:0]        rgb_next;

    assign in_win = (pixel_x >= X0) && (pixel_x < X1) &&
                    (pixel_y >= Y0) && (pixel_y < Y1);

    // Halving the offsets gives the 2x scale for free.
    assign dx_half  = 6'((pixel_x - X0) >> 1);
    assign row      = 4'((pixel_y - Y0) >> 1);
    assign char_idx = dx_half[5:3];
    assign col      = dx_half[2:0];

    // Character 0 shows switch[7]; 7-n == ~n for 3 bits.
    assign digit = switch[~char_idx];

    font_rom_bin u_font (
        .digit    (digit),
        .row      (row),
        .row_bits (row_bits)
    );

    assign pix_on = row_bits[~col];

    always_comb begin
        rgb_next = 3'b000;
        if (video_on) begin
            rgb_next = (in_win && pix_on) ? FG_RGB : BG_RGB;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_text <= 3'b000;
        end else begin
            rgb_text <= rgb_next;
        end
    end

endmodule

// File: tb/tb_generador_datos_texto.sv
// Directed checks and a partial raster sweep of generador_datos_texto.
module tb_generador_datos_texto;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic [7:0] switch;
    logic [2:0] rgb_text;

    int n_checks = 0;
    int n_fails  = 0;

    always #20 clk = ~clk;

    generador_datos_texto dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .video_on (video_on),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .switch   (switch),
        .rgb_text (rgb_text)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fails++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic bit glyph_bit(input bit d, input int r, input int c);
        if (!d)
            return ((r == 2 || r == 13) && c >= 2 && c <= 5) ||
                   (r >= 3 && r <= 12 && (c == 1 || c == 6));
        return (r >= 2 && r <= 13 && (c == 3 || c == 4)) ||
               (r == 3 && c == 2) ||
               (r == 13 && c >= 2 && c <= 5);
    endfunction

    function automatic int exp_rgb(input int x, input int y,
                                   input logic [7:0] sw, input bit vo);
        int dx, ch;
        if (!vo) return 0;
        if (x < 256 || x >= 384 || y < 224 || y >= 256) return 0;
        dx = x - 256;
        ch = dx / 16;
        return glyph_bit(sw[7-ch], (y - 224) / 2, (dx % 16) / 2) ? 7 : 0;
    endfunction

    task automatic pix(input string tag, input int x, input int y,
                       input bit vo, input logic [7:0] sw, input int exp);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = vo;
        switch   = sw;
        @(posedge clk);
        #1;
        chk(tag, int'(rgb_text), exp);
    endtask

    initial begin
        int ones, outside_set, model_err, got;

        reset_n  = 1'b0;
        video_on = 1'b1;
        pixel_x  = 10'd326;
        pixel_y  = 10'd234;
        switch   = 8'b0000_1000;
        #1;
        chk("rst_state", int'(rgb_text), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold", int'(rgb_text), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release", int'(rgb_text), 7);

        // Mid-frame asynchronous reset between edges.
        #5 reset_n = 1'b0;
        #1;
        chk("rst_async", int'(rgb_text), 0);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_recover", int'(rgb_text), 7);

        pix("one_c4",    326, 234, 1'b1, 8'h08, 7);
        pix("zero_col1", 258, 234, 1'b1, 8'h08, 7);
        pix("zero_col3", 262, 234, 1'b1, 8'h08, 0);
        pix("out_left",  100, 234, 1'b1, 8'h08, 0);
        pix("out_above", 326, 200, 1'b1, 8'h08, 0);
        pix("out_right", 384, 234, 1'b1, 8'h08, 0);
        pix("out_max",   639, 479, 1'b1, 8'h08, 0);
        pix("out_x255",  255, 241, 1'b1, 8'hFF, 0);
        pix("out_y256",  326, 256, 1'b1, 8'hFF, 0);
        pix("vid_off",   326, 234, 1'b0, 8'h08, 0);
        pix("sw_clear",  326, 234, 1'b1, 8'h00, 0);
        pix("msb_one",   262, 234, 1'b1, 8'h80, 7);
        pix("one_r3c2",  324, 230, 1'b1, 8'h08, 7);
        pix("one_r13c5", 330, 250, 1'b1, 8'h08, 7);
        pix("one_r12c5", 330, 248, 1'b1, 8'h08, 0);
        pix("zero_r2c5", 266, 228, 1'b1, 8'h00, 7);
        pix("zero_r2c1", 258, 228, 1'b1, 8'h00, 0);
        pix("zero_r12c6", 380, 248, 1'b1, 8'h00, 7);

        // Raster rows spanning the window plus margins, all columns.
        ones = 0;
        outside_set = 0;
        model_err = 0;
        switch   = 8'b0000_1000;
        video_on = 1'b1;
        for (int y = 216; y < 264; y++) begin
            for (int x = 0; x < 640; x++) begin
                pixel_x = 10'(x);
                pixel_y = 10'(y);
                @(posedge clk);
                #1;
                got = int'(rgb_text);
                if (got == 7) ones++;
                if (got != 0 && (x < 256 || x >= 384 || y < 224 || y >= 256))
                    outside_set++;
                if (got != exp_rgb(x, y, switch, 1'b1)) model_err++;
            end
        end
        chk("sweep_ones", ones, 892);
        chk("sweep_outside", outside_set, 0);
        chk("sweep_model", model_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
